// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: program-stream handshake and byte-wide instruction
// memory write port of the boot loader.
// master: the image source side (drives the stream, observes memory writes).
// slave : the loader side (accepts the stream, drives the memory port).
interface imem_boot_loader_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int IN_BYTES   = 4
);
    logic                    s_valid;
    logic [8*IN_BYTES-1:0]   s_data;
    logic                    s_ready;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [7:0]              mem_wdata;

    modport master (
        output s_valid, s_data,
        input  s_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: serialises a valid/ready byte-lane program stream into
// byte-addressed instruction memory (one byte per cycle, little-endian) and
// holds the core in reset until the complete image has been written.
// Optional feature macro: IMEM_BOOT_LOADER_CHECKSUM_EN -- when defined, a
// 16-bit byte-sum of the image is accumulated and must match the expected
// value for the load to succeed; when undefined csum_out stays 0.
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int IN_BYTES   = 4,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_load_start,
    input  logic [ADDR_WIDTH-1:0] i_load_base,
    input  logic [LEN_WIDTH-1:0]  i_load_len,
    input  logic [15:0]           i_load_csum,
    imem_boot_loader_if.slave     bus,
    output logic                  o_cpu_reset,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [15:0]           o_csum_out
);
    localparam int CNT_W = $clog2(IN_BYTES + 1);
    localparam int SUM_W = ((ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH) + 2;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;

    state_t                  r_state;
    logic                    r_cpu_reset;
    logic                    r_s_ready;
    logic                    r_mem_we;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [7:0]              r_mem_wdata;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_err;
    logic [15:0]             r_csum;
    logic [ADDR_WIDTH-1:0]   r_base;
    logic [LEN_WIDTH-1:0]    r_len;
    logic [LEN_WIDTH-1:0]    r_acc_cnt;   // bytes taken in from the stream
    logic [LEN_WIDTH-1:0]    r_wr_cnt;    // bytes written to memory
    logic [8*IN_BYTES-1:0]   r_buf;       // pending bytes, next one in [7:0]
    logic [CNT_W-1:0]        r_buf_cnt;   // number of pending bytes in r_buf

    logic                    w_accept;
    logic                    w_emit;
    logic [LEN_WIDTH-1:0]    w_remain;
    logic [CNT_W-1:0]        w_take;
    logic [CNT_W-1:0]        w_buf_cnt_nxt;
    logic [LEN_WIDTH-1:0]    w_acc_nxt;
    logic [SUM_W-1:0]        w_end;
    logic                    w_overflow;
    logic                    w_csum_ok;

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    logic [15:0]             r_csum_exp;

    // Byte-sum accumulation, wrapping modulo 2^16
    function automatic logic [15:0] csum_add(input logic [15:0] acc, input logic [7:0] b);
        return acc + {8'h00, b};
    endfunction

    assign w_csum_ok = (r_csum == r_csum_exp);
`else
    logic                    w_unused_csum;
    assign w_unused_csum = ^i_load_csum;
    assign w_csum_ok     = 1'b1;
`endif

    // The image must end at or below the top of memory; widened so the sum cannot wrap
    assign w_end      = SUM_W'(i_load_base) + SUM_W'(i_load_len);
    assign w_overflow = (w_end > (SUM_W'(1) << ADDR_WIDTH));

    // Beat acceptance, bytes taken from a beat, and next buffer/counter values
    always_comb begin
        w_accept      = (r_state == S_LOAD) && bus.s_valid && r_s_ready;
        w_emit        = (r_state == S_LOAD) && (r_buf_cnt != '0);
        w_remain      = r_len - r_acc_cnt;
        w_take        = (w_remain >= LEN_WIDTH'(IN_BYTES)) ? CNT_W'(IN_BYTES) : CNT_W'(w_remain);
        w_buf_cnt_nxt = r_buf_cnt;
        w_acc_nxt     = r_acc_cnt;
        if (w_accept) begin
            // a beat only lands when at most the last old byte is leaving this cycle
            w_buf_cnt_nxt = w_take;
            w_acc_nxt     = r_acc_cnt + LEN_WIDTH'(w_take);
        end else if (w_emit) begin
            w_buf_cnt_nxt = r_buf_cnt - CNT_W'(1);
        end
    end

    // Load FSM with the byte buffer and all registered outputs
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_cpu_reset <= 1'b1;
            r_s_ready   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_csum      <= '0;
            r_base      <= '0;
            r_len       <= '0;
            r_acc_cnt   <= '0;
            r_wr_cnt    <= '0;
            r_buf       <= '0;
            r_buf_cnt   <= '0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            r_csum_exp  <= '0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (r_wr_cnt == r_len) begin
                        // every byte has been written: judge the image
                        r_busy    <= 1'b0;
                        r_s_ready <= 1'b0;
                        if (w_csum_ok) begin
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_cpu_reset <= 1'b0;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end else begin
                        if (w_emit) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_base + ADDR_WIDTH'(r_wr_cnt);
                            r_mem_wdata <= r_buf[7:0];
                            r_wr_cnt    <= r_wr_cnt + LEN_WIDTH'(1);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                            r_csum      <= csum_add(r_csum, r_buf[7:0]);
`endif
                        end
                        if (w_accept) begin
                            r_buf <= bus.s_data;
                        end else if (w_emit) begin
                            r_buf <= r_buf >> 8;
                        end
                        r_buf_cnt <= w_buf_cnt_nxt;
                        r_acc_cnt <= w_acc_nxt;
                        r_s_ready <= (w_buf_cnt_nxt <= CNT_W'(1)) && (w_acc_nxt != r_len);
                    end
                end
                default: begin
                    // IDLE, DONE and ERR all wait for a new load request
                    if (i_load_start) begin
                        r_cpu_reset <= 1'b1;
                        r_done      <= 1'b0;
                        r_err       <= 1'b0;
                        r_busy      <= 1'b0;
                        r_s_ready   <= 1'b0;
                        if (w_overflow) begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end else if (i_load_len == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_LOAD;
                            r_busy     <= 1'b1;
                            r_s_ready  <= 1'b1;
                            r_base     <= i_load_base;
                            r_len      <= i_load_len;
                            r_acc_cnt  <= '0;
                            r_wr_cnt   <= '0;
                            r_buf_cnt  <= '0;
                            r_csum     <= '0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                            r_csum_exp <= i_load_csum;
`endif
                        end
                    end
                end
            endcase
        end
    end

    assign bus.s_ready    = r_s_ready;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign o_cpu_reset    = r_cpu_reset;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_err          = r_err;
    assign o_csum_out     = r_csum;
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed bench for imem_boot_loader with a write
// scoreboard (expected address/byte pairs queued as beats are driven).
module tb_imem_boot_loader;
    localparam int AW = 10;
    localparam int IB = 4;
    localparam int LW = 16;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_start = 1'b0;
    logic [AW-1:0] load_base = '0;
    logic [LW-1:0] load_len = '0;
    logic [15:0]   load_csum = '0;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          err;
    logic [15:0]   csum_out;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_addr = 0;
    int last_acc_cyc = 0;
    logic [23:0] exp_q[$];
    int          wr_cyc_q[$];
    logic [31:0] fib[6] = '{32'h00100310, 32'h00000390, 32'h00030410,
                            32'h00730330, 32'h00040390, 32'hFFFF42EC};

    imem_boot_loader_if #(.ADDR_WIDTH(AW), .IN_BYTES(IB)) bus ();

    imem_boot_loader #(.ADDR_WIDTH(AW), .IN_BYTES(IB), .LEN_WIDTH(LW)) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_load_start (load_start),
        .i_load_base  (load_base),
        .i_load_len   (load_len),
        .i_load_csum  (load_csum),
        .bus          (bus),
        .o_cpu_reset  (cpu_reset),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .o_csum_out   (csum_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] beat_sum(input logic [31:0] d, input int n);
        logic [15:0] s = 16'h0;
        for (int i = 0; i < n; i++) s = s + {8'h00, d[8*i +: 8]};
        return s;
    endfunction

    function automatic logic [15:0] exp_csum(input logic [15:0] s);
        return CSUM_EN ? s : 16'h0000;
    endfunction

    // Scoreboard: every memory write must match the next expected (addr, byte)
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            logic [23:0] e;
            wr_cyc_q.push_back(cyc);
            chk("wr_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.mem_addr), 32'(e[23:8]));
                chk("wr_data", 32'(bus.mem_wdata), 32'(e[7:0]));
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic start(input int base, input int len, input logic [15:0] cs);
        load_base  = AW'(base);
        load_len   = LW'(len);
        load_csum  = cs;
        load_start = 1'b1;
        exp_addr   = base;
        wr_cyc_q.delete();
        @(posedge clk);
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input int idle, input int nbytes);
        int n = 0;
        for (int i = 0; i < nbytes; i++) begin
            exp_q.push_back({16'(exp_addr), d[8*i +: 8]});
            exp_addr++;
        end
        while (bus.s_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", 32'(bus.s_ready), 32'd1);
        repeat (idle) @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        @(posedge clk);
        @(negedge clk);
        bus.s_valid  = 1'b0;
        last_acc_cyc = cyc;
    endtask

    task automatic wait_end(output int c);
        int n = 0;
        while (!(done === 1'b1 || err === 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("end_timeout", 32'(done === 1'b1 || err === 1'b1), 32'd1);
        c = cyc;
    endtask

    initial begin
        logic [15:0] fib_sum;
        logic [15:0] s5;
        int acc0;
        int cend;
        int maxgap;
        int n;

        fib_sum = 16'h0;
        for (int i = 0; i < 6; i++) fib_sum = fib_sum + beat_sum(fib[i], 4);
        bus.s_valid = 1'b0;
        bus.s_data  = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_csum", 32'(csum_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Fibonacci image, back-to-back beats
        start(0, 24, fib_sum);
        chk("fib_start_busy", 32'(busy), 32'd1);
        chk("fib_start_ready", 32'(bus.s_ready), 32'd1);
        chk("fib_start_cpu_reset", 32'(cpu_reset), 32'd1);
        acc0 = 0;
        for (int i = 0; i < 6; i++) begin
            send_beat(fib[i], 0, 4);
            if (i == 0) acc0 = last_acc_cyc;
        end
        wait_end(cend);
        chk("fib_done", 32'(done), 32'd1);
        chk("fib_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("fib_err", 32'(err), 32'd0);
        chk("fib_latency", 32'(cend - acc0), 32'd25);
        chk("fib_nwr", 32'(wr_cyc_q.size()), 32'd24);
        chk("fib_first_wr", 32'(wr_cyc_q[0] - acc0), 32'd1);
        chk("fib_span", 32'(wr_cyc_q[23] - wr_cyc_q[0]), 32'd23);
        chk("fib_csum", 32'(csum_out), 32'(exp_csum(fib_sum)));
        chk("fib_q_empty", 32'(exp_q.size()), 32'd0);

        // Same image, stream stalls 3 ready cycles before beat 3
        start(0, 24, fib_sum);
        chk("stall_csum_clr", 32'(csum_out), 32'd0);
        chk("stall_done_clr", 32'(done), 32'd0);
        for (int i = 0; i < 6; i++) send_beat(fib[i], (i == 2) ? 3 : 0, 4);
        wait_end(cend);
        maxgap = 0;
        for (int i = 1; i < wr_cyc_q.size(); i++)
            if (wr_cyc_q[i] - wr_cyc_q[i-1] > maxgap) maxgap = wr_cyc_q[i] - wr_cyc_q[i-1];
        chk("stall_done", 32'(done), 32'd1);
        chk("stall_nwr", 32'(wr_cyc_q.size()), 32'd24);
        chk("stall_span", 32'(wr_cyc_q[23] - wr_cyc_q[0]), 32'd26);
        chk("stall_gap", 32'(maxgap), 32'd4);
        chk("stall_csum", 32'(csum_out), 32'(exp_csum(fib_sum)));

        // Length 5: short final beat keeps only its byte 0
        s5 = beat_sum(32'h44332211, 4) + beat_sum(32'hDEADBEAA, 1);
        start(100, 5, s5);
        send_beat(32'h44332211, 0, 4);
        send_beat(32'hDEADBEAA, 0, 1);
        wait_end(cend);
        repeat (2) @(negedge clk);
        chk("len5_done", 32'(done), 32'd1);
        chk("len5_nwr", 32'(wr_cyc_q.size()), 32'd5);
        chk("len5_csum", 32'(csum_out), 32'(exp_csum(s5)));
        chk("len5_q_empty", 32'(exp_q.size()), 32'd0);

        // Image ending exactly at the top of memory is legal
        start(1016, 8, beat_sum(32'h03020100, 4) + beat_sum(32'h07060504, 4));
        send_beat(32'h03020100, 0, 4);
        send_beat(32'h07060504, 0, 4);
        wait_end(cend);
        chk("top_done", 32'(done), 32'd1);
        chk("top_err", 32'(err), 32'd0);
        chk("top_nwr", 32'(wr_cyc_q.size()), 32'd8);

        // Overflowing image: immediate ERR, no writes
        start(1020, 8, 16'h0000);
        chk("ovf_err", 32'(err), 32'd1);
        chk("ovf_done", 32'(done), 32'd0);
        chk("ovf_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("ovf_ready", 32'(bus.s_ready), 32'd0);
        repeat (5) @(negedge clk);
        chk("ovf_nwr", 32'(wr_cyc_q.size()), 32'd0);
        chk("ovf_hold_err", 32'(err), 32'd1);
        start(0, 0, 16'h0000);
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_err", 32'(err), 32'd0);

        // Wrong expected checksum
        start(0, 24, 16'h0000);
        for (int i = 0; i < 6; i++) send_beat(fib[i], 0, 4);
        wait_end(cend);
        chk("badcs_nwr", 32'(wr_cyc_q.size()), 32'd24);
        chk("badcs_err", 32'(err), 32'(CSUM_EN));
        chk("badcs_done", 32'(done), 32'(!CSUM_EN));
        chk("badcs_cpu_reset", 32'(cpu_reset), 32'(CSUM_EN));

        // Reset pulsed mid-load, then a full restart
        start(0, 24, fib_sum);
        for (int i = 0; i < 3; i++) send_beat(fib[i], 0, 4);
        n = 0;
        while (wr_cyc_q.size() < 10 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reached10", 32'(wr_cyc_q.size() >= 10), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("mid_mem_we", 32'(bus.mem_we), 32'd0);
        chk("mid_ready", 32'(bus.s_ready), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_addr", 32'(bus.mem_addr), 32'd0);
        chk("mid_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("mid_csum", 32'(csum_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        start(0, 24, fib_sum);
        for (int i = 0; i < 6; i++) send_beat(fib[i], 0, 4);
        wait_end(cend);
        chk("restart_done", 32'(done), 32'd1);
        chk("restart_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("restart_nwr", 32'(wr_cyc_q.size()), 32'd24);
        chk("restart_csum", 32'(csum_out), 32'(exp_csum(fib_sum)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
